// File: rtl/datapath_pkg.sv
// Shared types, flag positions and the combinational ALU for pipelined_datapath.
// ALU and stage structs are sized to MAX_WIDTH / MAX_AW; instances narrow them.
package datapath_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_AW    = 8;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [3:0] {
        OP_PASSA = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_NOT   = 4'd6,
        OP_SHL1  = 4'd7,
        OP_SHR1  = 4'd8,
        OP_INC   = 4'd9,
        OP_DEC   = 4'd10,
        OP_PASSB = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } op_e;

    typedef logic [MAX_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t             result;
        logic [MAX_AW-1:0] dst;
        logic              we;
        logic              is_alu;
        logic              z;
        logic              n;
        logic              c;
    } wb_stage_t;

    typedef struct packed {
        word_t result;
        logic  c;
    } alu_out_t;

    // Operands are masked to w bits so carries and MSB tests land on the real width.
    function automatic alu_out_t alu(op_e op, word_t a, word_t b, int w);
        word_t              mask;
        word_t              msb;
        word_t              aa;
        word_t              bb;
        logic [MAX_WIDTH:0] wide;
        logic [MAX_WIDTH:0] cbit;
        alu_out_t           r;
        mask = (w >= MAX_WIDTH) ? '1 : ((word_t'(1) << w) - word_t'(1));
        msb  = word_t'(1) << (w - 1);
        cbit = {1'b0, mask} + {{MAX_WIDTH{1'b0}}, 1'b1};
        aa   = a & mask;
        bb   = b & mask;
        wide = '0;
        r    = '0;
        case (op)
            OP_PASSA: r.result = aa;
            OP_ADD: begin
                wide     = {1'b0, aa} + {1'b0, bb};
                r.result = wide[MAX_WIDTH-1:0];
                r.c      = |(wide & cbit);
            end
            OP_SUB: begin
                r.result = aa - bb;
                r.c      = (aa < bb);
            end
            OP_AND:   r.result = aa & bb;
            OP_OR:    r.result = aa | bb;
            OP_XOR:   r.result = aa ^ bb;
            OP_NOT:   r.result = ~aa;
            OP_SHL1: begin
                r.result = aa << 1;
                r.c      = |(aa & msb);
            end
            OP_SHR1: begin
                r.result = aa >> 1;
                r.c      = aa[0];
            end
            OP_INC: begin
                wide     = {1'b0, aa} + {{MAX_WIDTH{1'b0}}, 1'b1};
                r.result = wide[MAX_WIDTH-1:0];
                r.c      = |(wide & cbit);
            end
            OP_DEC: begin
                r.result = aa - word_t'(1);
                r.c      = (aa == '0);
            end
            OP_PASSB: r.result = bb;
            default:  r = '0;
        endcase
        r.result = r.result & mask;
        return r;
    endfunction

endpackage

// File: rtl/pipelined_datapath_if.sv
// Instruction-in / result-out bundle of pipelined_datapath.
// Handshake: a beat transfers on the rising edge where valid && ready; the producer
// holds its payload stable while valid && !ready, and ready never depends on the same-side valid.
interface pipelined_datapath_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [AW-1:0]    a_sel;
    logic [AW-1:0]    b_sel;
    logic [AW-1:0]    dst_sel;
    logic             write_en;
    logic             mux_sel;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_dst;
    logic [2:0]       flags;

    modport master (
        output in_valid, op, a_sel, b_sel, dst_sel, write_en, mux_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_dst, flags
    );

    modport slave (
        input  in_valid, op, a_sel, b_sel, dst_sel, write_en, mux_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_dst, flags
    );
endinterface

// File: rtl/regfile_mp.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module regfile_mp #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);
    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];
endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage datapath: read/ALU/load-mux into a WB stage, then retire into the
// register file with forwarding from WB, registered Z/N/C flags and an output stall.
module pipelined_datapath
    import datapath_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_datapath_if.slave  bus
);
    wb_stage_t        wb_q;
    logic             wb_valid;
    logic [2:0]       flags_q;
    logic [WIDTH-1:0] rf_a;
    logic [WIDTH-1:0] rf_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] wb_result;
    logic [AW-1:0]    wb_dst;
    logic             stall;
    logic             retire;
    logic             accept;
    logic             fwd_en;
    alu_out_t         alu_o;
    logic             unused_wide_bits;

    assign wb_result = wb_q.result[WIDTH-1:0];
    assign wb_dst    = wb_q.dst[AW-1:0];
    assign stall     = wb_valid && !bus.out_ready;
    assign retire    = wb_valid && bus.out_ready;
    assign accept    = bus.in_valid && !stall;
    // Only a committing WB item may bypass; compare-only items leave the file untouched.
    assign fwd_en    = wb_valid && wb_q.we;

    regfile_mp #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (bus.a_sel),
        .ra_data (rf_a),
        .rb_addr (bus.b_sel),
        .rb_data (rf_b),
        .wr_en   (retire && wb_q.we),
        .wr_addr (wb_dst),
        .wr_data (wb_result)
    );

    always_comb begin
        op_a   = (fwd_en && (wb_dst == bus.a_sel)) ? wb_result : rf_a;
        op_b   = (fwd_en && (wb_dst == bus.b_sel)) ? wb_result : rf_b;
        alu_o  = alu(op_e'(bus.op), word_t'(op_a), word_t'(op_b), WIDTH);
        result = bus.mux_sel ? bus.in_data : alu_o.result[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_q     <= '0;
            flags_q  <= '0;
        end else begin
            if (accept) begin
                wb_valid      <= 1'b1;
                wb_q.result   <= word_t'(result);
                wb_q.dst      <= MAX_AW'(bus.dst_sel);
                wb_q.we       <= bus.write_en;
                wb_q.is_alu   <= !bus.mux_sel;
                wb_q.z        <= (result == '0);
                wb_q.n        <= result[WIDTH-1];
                wb_q.c        <= !bus.mux_sel && alu_o.c;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end
            if (retire && wb_q.is_alu) begin
                flags_q[FLAG_Z] <= wb_q.z;
                flags_q[FLAG_N] <= wb_q.n;
                flags_q[FLAG_C] <= wb_q.c;
            end
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = wb_valid;
    assign bus.out_data  = wb_result;
    assign bus.out_dst   = wb_dst;
    assign bus.flags     = flags_q;

    // Upper bits of the max-width containers are zero for narrow instances.
    assign unused_wide_bits = ^{alu_o.result, wb_q.result, wb_q.dst};
endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath: retire-order scoreboard plus flag,
// stall and reset checks against hand-computed values.
module tb_pipelined_datapath;
  import datapath_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  pipelined_datapath_if #(.WIDTH(8), .AW(4)) bus ();

  pipelined_datapath #(.WIDTH(8), .NREGS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every retiring result must match the oldest expected value
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL retire_unexpected: got %0h, expected no retire", bus.out_data);
      end else begin
        check("retire_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic send(input logic [3:0] op, input int a, input int b, input int d,
                      input logic we, input logic mux, input logic [7:0] data,
                      input logic [7:0] exp, input bit push);
    int n;
    bus.op       = op;
    bus.a_sel    = 4'(a);
    bus.b_sel    = 4'(b);
    bus.dst_sel  = 4'(d);
    bus.write_en = we;
    bus.mux_sel  = mux;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic load(input int d, input logic [7:0] val);
    send(OP_PASSA, 0, 0, d, 1'b1, 1'b1, val, val, 1'b1);
  endtask

  task automatic run_op(input logic [3:0] op, input int a, input int b, input int d,
                        input logic we, input logic [7:0] exp);
    send(op, a, b, d, we, 1'b0, 8'h00, exp, 1'b1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a_sel     = 4'd0;
    bus.b_sel     = 4'd0;
    bus.dst_sel   = 4'd0;
    bus.write_en  = 1'b0;
    bus.mux_sel   = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #3;
    check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, bus.out_data}, 32'd0);
    check("rst_out_dst",   {28'd0, bus.out_dst}, 32'd0);
    check("rst_flags",     {29'd0, bus.flags}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // load, add, stall
    load(1, 8'h05);
    load(2, 8'h03);
    run_op(OP_ADD, 1, 2, 3, 1'b1, 8'h08);
    bus.out_ready = 1'b0;
    bus.op = OP_PASSA; bus.dst_sel = 4'd4; bus.mux_sel = 1'b1; bus.write_en = 1'b1;
    bus.in_data = 8'hAA; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_out_data",  {24'd0, bus.out_data}, 32'h08);
      check("stall_out_dst",   {28'd0, bus.out_dst}, 32'd3);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    load(4, 8'hAA);
    check("add_flags", {29'd0, bus.flags}, 32'b000);

    // forwarding chain
    load(1, 8'hFF);
    run_op(OP_INC, 1, 0, 1, 1'b1, 8'h00);
    run_op(OP_ADD, 1, 1, 2, 1'b1, 8'h00);
    check("inc_flags", {29'd0, bus.flags}, 32'b101);
    idle(1);
    check("fwd_add_flags", {29'd0, bus.flags}, 32'b100);

    // subtract and shift
    load(1, 8'h02);
    load(2, 8'h05);
    run_op(OP_SUB, 1, 2, 3, 1'b1, 8'hFD);
    load(4, 8'h81);
    check("sub_flags", {29'd0, bus.flags}, 32'b011);
    run_op(OP_SHL1, 4, 0, 5, 1'b1, 8'h02);
    check("load_keeps_flags", {29'd0, bus.flags}, 32'b011);
    idle(1);
    check("shl_flags", {29'd0, bus.flags}, 32'b001);

    // compare-only: no write, no forward, flags still update
    load(8, 8'h5A);
    load(6, 8'h33);
    load(7, 8'h33);
    run_op(OP_SUB, 6, 7, 8, 1'b0, 8'h00);
    run_op(OP_PASSA, 8, 0, 9, 1'b1, 8'h5A);
    check("cmp_flags", {29'd0, bus.flags}, 32'b100);
    idle(1);
    check("passa_flags", {29'd0, bus.flags}, 32'b000);

    // reserved opcode and flag retention
    load(12, 8'hFF);
    run_op(OP_INC, 12, 0, 13, 1'b1, 8'h00);
    run_op(4'hC, 12, 12, 10, 1'b1, 8'h00);
    check("inc2_flags", {29'd0, bus.flags}, 32'b101);
    load(13, 8'h80);
    check("rsv_flags", {29'd0, bus.flags}, 32'b100);
    idle(1);
    check("load80_keeps_flags", {29'd0, bus.flags}, 32'b100);

    // reset while WB holds a pending write
    bus.out_ready = 1'b0;
    send(OP_PASSA, 0, 0, 5, 1'b1, 1'b1, 8'h77, 8'h77, 1'b0);
    bus.in_valid = 1'b0;
    check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_flags",     {29'd0, bus.flags}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_data",  {24'd0, bus.out_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      run_op(OP_PASSA, r, 0, 0, 1'b0, 8'h00);
    end
    idle(3);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
